// File: rtl/demux1to4_dispatch.sv
// One-to-four dispatcher: routes each accepted word to the holding register of
// the channel named by in_sel and counts the words each channel delivers.
//
// state | meaning (per channel k, encoded by valid_q[k])
// EMPTY | no word held, out_valid[k]=0, channel can take a word
// FULL  | word held in data_q[k], out_valid[k]=1, waiting for out_ready[k]
module demux1to4_dispatch #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [7:0]       xfer_cnt0,
  output logic [7:0]       xfer_cnt1,
  output logic [7:0]       xfer_cnt2,
  output logic [7:0]       xfer_cnt3
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;

  chan_state_t      state_q [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [7:0]       cnt_q   [4];
  logic [3:0]       valid_q;
  logic [3:0]       drain;
  logic             accept;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      valid_q[k] = (state_q[k] == FULL);
    end
  end

  // Only the addressed channel decides readiness, so a stalled channel never
  // blocks traffic to the others.
  assign in_ready = ~valid_q[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;
  assign drain    = valid_q & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        // A load takes priority over a drain so a channel streams without a bubble.
        if (accept && (in_sel == 2'(k))) begin
          state_q[k] <= FULL;
          data_q[k]  <= in_data;
        end else if (drain[k]) begin
          state_q[k] <= EMPTY;
        end
        if (drain[k]) begin
          cnt_q[k] <= cnt_q[k] + 8'd1;
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign xfer_cnt0 = cnt_q[0];
  assign xfer_cnt1 = cnt_q[1];
  assign xfer_cnt2 = cnt_q[2];
  assign xfer_cnt3 = cnt_q[3];

endmodule

// File: tb/tb_demux1to4_dispatch.sv
// Directed bench for demux1to4_dispatch: routing, back-pressure, streaming,
// counter wrap and reset behaviour against hand-computed values.
module tb_demux1to4_dispatch;

  logic       clk;
  logic       rst;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] xfer_cnt0, xfer_cnt1, xfer_cnt2, xfer_cnt3;

  int checks = 0;
  int errors = 0;

  demux1to4_dispatch #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt0 (xfer_cnt0),
    .xfer_cnt1 (xfer_cnt1),
    .xfer_cnt2 (xfer_cnt2),
    .xfer_cnt3 (xfer_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;
    step(); step();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // first accept on the first edge after release
    rst = 1'b0;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 4'hA;
    #1; check("route_rdy0", 32'(in_ready), 32'h1);
    step();
    check("route_v0", 32'(out_valid), 32'h1);
    check("route_d0", 32'(out_data0), 32'hA);
    in_sel = 2'd1; in_data = 4'h5; step();
    in_sel = 2'd2; in_data = 4'hC; step();
    in_sel = 2'd3; in_data = 4'h3; step();
    check("route_vall", 32'(out_valid), 32'hF);
    check("route_d1", 32'(out_data1), 32'h5);
    check("route_d2", 32'(out_data2), 32'hC);
    check("route_d3", 32'(out_data3), 32'h3);
    in_sel = 2'd2; in_data = 4'hF;
    #1; check("route_full_rdy", 32'(in_ready), 32'h0);
    step();
    check("route_full_d2", 32'(out_data2), 32'hC);
    check("route_full_v", 32'(out_valid), 32'hF);

    // drain channel 3 only, then back-pressure isolation
    in_valid = 1'b0; out_ready = 4'b1000; step();
    check("bp_drain_v", 32'(out_valid), 32'h7);
    check("bp_cnt3", 32'(xfer_cnt3), 32'h1);
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 4'h7;
    #1; check("bp_rdy1", 32'(in_ready), 32'h0);
    step();
    check("bp_d1_hold", 32'(out_data1), 32'h5);
    check("bp_v_hold", 32'(out_valid), 32'h7);
    in_sel = 2'd3; in_data = 4'h9;
    #1; check("bp_rdy3", 32'(in_ready), 32'h1);
    step();
    check("bp_d3", 32'(out_data3), 32'h9);
    check("bp_v3", 32'(out_valid), 32'hF);

    // asynchronous reset with all channels full, no clock edge
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_data", {out_data0, out_data1, out_data2, out_data3}, 32'h0);
    check("arst_cnt3", 32'(xfer_cnt3), 32'h0);
    check("arst_rdy", 32'(in_ready), 32'h1);
    step();
    rst = 1'b0;

    // in_sel/in_data ignored while in_valid=0; out_ready on empty channels does nothing
    in_sel = 2'd2; in_data = 4'hE; out_ready = 4'b1111;
    step();
    check("idle_valid", 32'(out_valid), 32'h0);
    check("idle_cnts", {xfer_cnt0, xfer_cnt1, xfer_cnt2, xfer_cnt3}, 32'h0);

    // streaming into channel 2
    in_valid = 1'b1; in_sel = 2'd2;
    for (int i = 0; i < 10; i++) begin
      in_data = 4'(i);
      #1; check("stream_rdy", 32'(in_ready), 32'h1);
      step();
      check("stream_d2", 32'(out_data2), 32'(i));
      check("stream_cnt2", 32'(xfer_cnt2), 32'(i));
    end
    in_valid = 1'b0; step();
    check("stream_cnt_final", 32'(xfer_cnt2), 32'd10);
    check("stream_v_final", 32'(out_valid), 32'h0);

    // 256 drains on channel 0
    out_ready = 4'b0001; in_valid = 1'b1; in_sel = 2'd0;
    for (int i = 0; i < 256; i++) begin
      in_data = 4'(i);
      step();
    end
    check("wrap_cnt0_255", 32'(xfer_cnt0), 32'd255);
    in_valid = 1'b0; step();
    check("wrap_cnt0", 32'(xfer_cnt0), 32'd0);
    check("wrap_others", {8'h0, xfer_cnt1, xfer_cnt2, xfer_cnt3}, 32'h000A00);

    // reset while channel 3 is full and draining
    out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd3; in_data = 4'h6;
    step();
    check("mid_v3", 32'(out_valid), 32'h8);
    in_valid = 1'b0; out_ready = 4'b1000; rst = 1'b1;
    step();
    check("mid_v", 32'(out_valid), 32'h0);
    check("mid_cnt3", 32'(xfer_cnt3), 32'h0);
    check("mid_cnt2", 32'(xfer_cnt2), 32'h0);
    rst = 1'b0; out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 4'h4;
    step();
    check("post_v", 32'(out_valid), 32'h2);
    check("post_d1", 32'(out_data1), 32'h4);
    in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1to4_dispatch.md
DEMUX1TO4_DISPATCH -- requirements
Module: demux1to4_dispatch

Interface
REQ-001 Parameter: WIDTH, default 4, data width of input and of each output channel.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_data  input  WIDTH  word to be dispatched.
REQ-005 in_sel  input  2  destination channel index (0..3), sampled with in_data.
REQ-006 in_valid  input  1  upstream offers in_data/in_sel this cycle.
REQ-007 in_ready  output  1  block accepts the offered word this cycle (combinational).
REQ-008 out_data0..out_data3  output  WIDTH each  registered channel data.
REQ-009 out_valid[3:0]  output  4  bit k: channel k holds a word.
REQ-010 out_ready[3:0]  input  4  bit k: downstream consumer k takes the word this cycle.
REQ-011 xfer_cnt0..xfer_cnt3  output  8 each  count of words delivered on channel k (out_valid[k] & out_ready[k]).

Function
REQ-012 Each channel k SHALL have one holding register (data + valid flag); states per channel: EMPTY (out_valid[k]=0), FULL (out_valid[k]=1).
REQ-013 in_ready SHALL equal (~out_valid[in_sel]) | out_ready[in_sel]; it depends only on the selected channel.
REQ-014 Accept = in_valid & in_ready; on accept, out_data<in_sel> SHALL load in_data and out_valid[in_sel] SHALL be 1 on the next cycle (latency 1 cycle, input to output).
REQ-015 Drain on channel k = out_valid[k] & out_ready[k]; absent a same-cycle accept to k, out_valid[k] SHALL go 0 next cycle.
REQ-016 Simultaneous drain and accept on the same channel SHALL keep out_valid[k]=1 and load the new word (full throughput, one word per cycle per channel, no bubble).
REQ-017 Channels SHALL be independent: a FULL, stalled channel SHALL NOT block accepts to other channels.
REQ-018 At most one channel SHALL load per cycle; unselected channels' data SHALL hold.
REQ-019 out_data<k> SHALL hold stable while out_valid[k]=1 and out_ready[k]=0.
REQ-020 No word SHALL be dropped or duplicated; in_valid with in_ready=0 SHALL leave all state unchanged.
REQ-021 xfer_cnt<k> SHALL increment by 1 on each drain of channel k, wrap 255 -> 0, and not saturate.
REQ-022 out_ready[k] while out_valid[k]=0 SHALL have no effect (no count increment).
REQ-023 in_sel and in_data SHALL be ignored when in_valid=0.

Reset
REQ-024 While rst=1, immediately and without a clock: out_valid=4'b0000, all out_data<k>=0, all xfer_cnt<k>=0.
REQ-025 in_ready SHALL read 1 during and after reset (all channels EMPTY).
REQ-026 Reset asserted mid-operation SHALL discard all held words; no drain or count is credited in the reset cycle.
REQ-027 First accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-028 Reset: rst=1 with channels FULL -> out_valid=0000, out_data*=0, xfer_cnt*=0, in_ready=1 without a clock edge.
REQ-029 Routing: send 4'hA sel 0, 4'h5 sel 1, 4'hC sel 2, 4'h3 sel 3 with out_ready=0000 -> out_valid=1111, out_data0..3=A,5,C,3; a fifth word to sel 2 sees in_ready=0.
REQ-030 Back-pressure isolation: channel 1 FULL with out_ready[1]=0; offer sel 1 -> in_ready=0, state unchanged; offer sel 3 -> accepted, out_data3 updated next cycle.
REQ-031 Streaming: out_ready=1111, in_valid=1, sel=2 for 10 cycles with data 0..9 -> in_ready=1 every cycle, out_data2 tracks data one cycle late, xfer_cnt2=9 one cycle after last accept, then 10 after final drain.
REQ-032 Wrap: 256 drains on channel 0 -> xfer_cnt0 returns to 0; other counters unchanged.
REQ-033 Mid-reset: rst pulsed while channel 3 FULL and draining -> out_valid[3]=0, xfer_cnt3=0, no increment credited.
